fetch_stage: RTL



---
 rtl/fetch_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Y86-64 fetch stage: instruction memory, decode of fields, F and D pipeline registers
//
// Optional feature macro: FETCH_ADR_CHECK_EN (out-of-range fetches raise ADR;
// without it byte addresses wrap modulo IMEM_BYTES and ADR is never produced).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   f_PC                      selected fetch PC (combinational, same cycle)
//   F_stall                   hold F_predPC
//   D_stall, D_bubble         hold / load nop into the D register (stall wins)
//   imem_we/addr/wdata        synchronous byte write into instruction memory
//   F_predPC                  registered predicted PC
//   D_stat, D_icode, D_ifun   registered status, instruction code and function
//   D_rA, D_rB                registered register IDs (0xF = none)
//   D_valC, D_valP            registered constant word and next sequential PC

module fetch_stage #(
  parameter int IMEM_BYTES = 1024,
  parameter int IMEM_AW    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        f_PC,
  input  logic               F_stall,
  input  logic               D_stall,
  input  logic               D_bubble,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_addr,
  input  logic [7:0]         imem_wdata,
  output logic [63:0]        F_predPC,
  output logic [2:0]         D_stat,
  output logic [3:0]         D_icode,
  output logic [3:0]         D_ifun,
  output logic [3:0]         D_rA,
  output logic [3:0]         D_rB,
  output logic [63:0]        D_valC,
  output logic [63:0]        D_valP
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] R_NONE = 4'hF;

  logic [7:0] mem [IMEM_BYTES];

  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
  end

  // The longest instruction is 10 bytes; read all of them, wrapping in the array.
  logic [7:0] b [10];
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      b[k] = mem[f_PC[IMEM_AW-1:0] + IMEM_AW'(k)];
    end
  end

  logic [3:0]  icode, ifun;
  logic [3:0]  len;
  logic        need_regids, need_valc, valid;
  logic [63:0] valc;

  assign icode = b[0][7:4];
  assign ifun  = b[0][3:0];

  always_comb begin
    len         = 4'd1;
    need_regids = 1'b0;
    need_valc   = 1'b0;
    valid       = 1'b0;
    case (icode)
      4'h0, 4'h1, 4'h9: begin
        valid = (ifun == 4'h0);
      end
      4'h2: begin
        len = 4'd2; need_regids = 1'b1; valid = (ifun <= 4'h6);
      end
      4'h6: begin
        len = 4'd2; need_regids = 1'b1; valid = (ifun <= 4'h3);
      end
      4'hA, 4'hB: begin
        len = 4'd2; need_regids = 1'b1; valid = (ifun == 4'h0);
      end
      4'h7: begin
        len = 4'd9; need_valc = 1'b1; valid = (ifun <= 4'h6);
      end
      4'h8: begin
        len = 4'd9; need_valc = 1'b1; valid = (ifun == 4'h0);
      end
      4'h3, 4'h4, 4'h5: begin
        len = 4'd10; need_regids = 1'b1; need_valc = 1'b1; valid = (ifun == 4'h0);
      end
      default: begin
        valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    valc = 64'd0;
    if (need_valc) begin
      if (need_regids) valc = {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]};
      else             valc = {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
    end
  end

  logic [3:0] len_eff;
  logic       adr;

`ifdef FETCH_ADR_CHECK_EN
  logic        pc_oob;
  logic [63:0] last_addr;
  // If byte 0 is already out of range the decoded length is meaningless; treat it as 1.
  assign pc_oob    = (f_PC >> IMEM_AW) != 64'd0;
  assign len_eff   = pc_oob ? 4'd1 : len;
  assign last_addr = f_PC + 64'(len) - 64'd1;
  assign adr       = pc_oob | ((last_addr >> IMEM_AW) != 64'd0);
`else
  assign len_eff = len;
  assign adr     = 1'b0;
`endif

  logic [63:0] valp, pred;
  logic [2:0]  stat;
  logic        err;

  assign valp = f_PC + 64'(len_eff);
  assign err  = adr | ~valid;

  always_comb begin
    if (adr)                stat = STAT_ADR;
    else if (!valid)        stat = STAT_INS;
    else if (icode == 4'h0) stat = STAT_HLT;
    else                    stat = STAT_AOK;
  end

  assign pred = (!err && (icode == I_JXX || icode == I_CALL)) ? valc : valp;

  always_ff @(posedge clk) begin
    if (rst) begin
      F_predPC <= 64'd0;
    end else if (!F_stall) begin
      F_predPC <= pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (!D_stall && D_bubble)) begin
      D_stat  <= STAT_AOK;
      D_icode <= I_NOP;
      D_ifun  <= 4'h0;
      D_rA    <= R_NONE;
      D_rB    <= R_NONE;
      D_valC  <= 64'd0;
      D_valP  <= 64'd0;
    end else if (!D_stall) begin
      D_stat  <= stat;
      D_icode <= err ? I_NOP : icode;
      D_ifun  <= err ? 4'h0 : ifun;
      D_rA    <= need_regids ? b[1][7:4] : R_NONE;
      D_rB    <= need_regids ? b[1][3:0] : R_NONE;
      D_valC  <= valc;
      D_valP  <= valp;
    end
  end

endmodule
